// File: rtl/reg_bus_engine.sv
// Single-bus register engine: four-phase sequencer moving operands over one shared
// bus through Y/Z staging registers into a general register file, with a HI product half.
module reg_bus_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 16,
    localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AW-1:0]     cmd_ra,
    input  logic [AW-1:0]     cmd_rb,
    input  logic [AW-1:0]     cmd_rc,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi_out,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ADDI, OP_MOVE, OP_LDI
    } op_t;

    state_t                state;
    op_t                   op_q;
    logic [AW-1:0]         ra_q;
    logic [AW-1:0]         rb_q;
    logic [AW-1:0]         rc_q;
    logic [DATA_W-1:0]     imm_q;
    logic [DATA_W-1:0]     y;
    logic [2*DATA_W-1:0]   z;
    logic [2*DATA_W-1:0]   alu;
    logic [2*DATA_W-1:0]   y_ext;
    logic [2*DATA_W-1:0]   b_ext;
    logic [DATA_W-1:0]     bus;
    logic [DATA_W-1:0]     rd_b;
    logic [DATA_W-1:0]     rd_c;
    logic [DATA_W-1:0]     regs [NREGS];

    // Indices past the populated file read as zero and swallow writes.
    function automatic logic in_range(input logic [AW-1:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    assign rd_b     = in_range(rb_q)    ? regs[rb_q]    : '0;
    assign rd_c     = in_range(rc_q)    ? regs[rc_q]    : '0;
    assign dbg_data = in_range(dbg_sel) ? regs[dbg_sel] : '0;

    // One bus driver per phase.
    always_comb begin
        bus = '0;
        case (state)
            T1:      bus = rd_b;
            T2:      bus = (op_q == OP_ADDI || op_q == OP_LDI) ? imm_q : rd_c;
            T3:      bus = z[DATA_W-1:0];
            default: bus = '0;
        endcase
    end

    assign y_ext = {{DATA_W{1'b0}}, y};
    assign b_ext = {{DATA_W{1'b0}}, bus};

    always_comb begin
        alu = '0;
        case (op_q)
            OP_ADD,
            OP_ADDI: alu = {{DATA_W{1'b0}}, DATA_W'(y + bus)};
            OP_SUB:  alu = {{DATA_W{1'b0}}, DATA_W'(y - bus)};
            OP_AND:  alu = {{DATA_W{1'b0}}, y & bus};
            OP_OR:   alu = {{DATA_W{1'b0}}, y | bus};
            OP_MUL:  alu = y_ext * b_ext;
            OP_MOVE: alu = y_ext;
            OP_LDI:  alu = b_ext;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            imm_q     <= '0;
            y         <= '0;
            z         <= '0;
            hi_out    <= '0;
            result    <= '0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        ra_q      <= cmd_ra;
                        rb_q      <= cmd_rb;
                        rc_q      <= cmd_rc;
                        imm_q     <= cmd_imm;
                        cmd_ready <= 1'b0;
                        state     <= T1;
                    end
                end
                T1: begin
                    y     <= bus;
                    state <= T2;
                end
                T2: begin
                    z     <= alu;
                    state <= T3;
                end
                T3: begin
                    if (in_range(ra_q)) regs[ra_q] <= bus;
                    result <= bus;
                    if (op_q == OP_MUL) hi_out <= z[2*DATA_W-1:DATA_W];
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_bus_engine.md
REG_BUS_ENGINE -- requirements
Module: reg_bus_engine

Interface
REQ-001 Parameter DATA_W, default 32: width of bus, register file, Y, Z halves, HI.
REQ-002 Parameter NREGS, default 16: number of general registers; AW = max(1, clog2(NREGS)).
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  engine idle, command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 ADDI, 6 MOVE, 7 LDI.
REQ-008 cmd_ra / cmd_rb / cmd_rc  input  AW each  destination / source A / source B register index.
REQ-009 cmd_imm  input  DATA_W  immediate for ADDI, LDI.
REQ-010 done  output  1  one-cycle pulse, destination written.
REQ-011 result  output  DATA_W  value written by the last completed command.
REQ-012 hi_out  output  DATA_W  HI register contents.
REQ-013 dbg_sel  input  AW  debug read index; dbg_data  output  DATA_W  combinational contents of register dbg_sel.

Function
REQ-014 FSM states IDLE, T1, T2, T3; cmd_ready = 1 only in IDLE.
REQ-015 On acceptance all cmd_* fields latched; later input changes have no effect on the command in flight.
REQ-016 Acceptance edge moves IDLE->T1; T1->T2->T3->IDLE unconditionally, one edge each.
REQ-017 T1: bus = R[rb], Y <= bus (LDI: Y loaded, unused).
REQ-018 T2: bus = R[rc] (ADD/SUB/AND/OR/MUL) or latched imm (ADDI/LDI); Z <= ALU(Y, bus), Z is 2*DATA_W.
REQ-019 ALU: ADD Y+B, SUB Y-B, ADDI Y+imm, all modulo 2^DATA_W, Z high = 0; AND/OR bitwise; MOVE Z low = Y; LDI Z low = imm; MUL unsigned full 2*DATA_W product.
REQ-020 T3: bus = Z low, R[ra] <= bus, result <= bus; MUL only: HI <= Z high; HI unchanged otherwise.
REQ-021 Latency: accepted at edge k -> R[ra], result updated at edge k+3; done = 1 for the cycle after edge k+3 only; cmd_ready = 1 in that same cycle, so back-to-back commands may be accepted every 4 cycles.
REQ-022 Exactly one bus source per state; bus = 0 in IDLE.
REQ-023 ra equal to rb and/or rc: sources read in T1/T2 before T3 write; result uses old values.
REQ-024 Index >= NREGS: read returns 0, write discarded (done still pulses, result still updated); dbg_data same rule.
REQ-025 cmd_valid while not in IDLE ignored, no queueing.
REQ-026 No overflow or carry flag; wrap silently.

Reset
REQ-027 clear high: FSM -> IDLE immediately, all R[i], Y, Z, HI, result = 0, done = 0, cmd_ready = 1 on release.
REQ-028 clear mid-command aborts it; no register write from the aborted command, no done pulse.
REQ-029 No command accepted on any edge where clear is high.

Verification
REQ-030 LDI ra=1 imm=0x0000_0005, then LDI ra=2 imm=0x0000_0003, ADD ra=3 rb=1 rc=2 -> done 3 edges after each acceptance, result=8, dbg_sel=3 reads 8.
REQ-031 SUB ra=4 rb=2 rc=1 (3-5) -> result=0xFFFF_FFFE, hi_out unchanged.
REQ-032 LDI R1=0xFFFF_FFFF, MUL ra=5 rb=1 rc=1 -> result=0x0000_0001, hi_out=0xFFFF_FFFE.
REQ-033 ADD ra=1 rb=1 rc=1 with R1=7 -> R1=14; cmd_valid held high during T1-T3 with different fields -> ignored, next acceptance only in done cycle.
REQ-034 Assert clear during T2 of ADD ra=6 -> R6=0, no done, cmd_ready=1 after release; all registers read 0.
REQ-035 Parameter sweep DATA_W=8, NREGS=12: ADDI ra=3 rb=0 imm=0xFF with R0=2 -> result=0x01; write to index 13 discarded, dbg_sel=13 reads 0.
